// File: rtl/pdm_audio_pkg.sv
// Shared widths and helpers for the PDM-to-PCM audio path: CIC decimator
// followed by a 4-bit error-feedback requantiser.
package pdm_audio_pkg;

    localparam int CIC_ORDER = 3;
    localparam int PCM_W     = 16;
    localparam int DAC_W     = 4;
    localparam int ERR_W     = 12;

    // Number of decimation ticks whose output is discarded after reset
    localparam logic [1:0] WARMUP_TICKS = 2'd3;

    function automatic int cic_width(input int decim_log2);
        return CIC_ORDER * decim_log2 + 1;
    endfunction

endpackage

// File: rtl/dac_noise_shaper.sv
// First-order error-feedback requantiser: 16-bit PCM to a 4-bit DAC code whose
// time-average tracks the sample, clamping at top of scale.
module dac_noise_shaper
    import pdm_audio_pkg::*;
(
    input  logic             pixclk,
    input  logic             rst,
    input  logic [PCM_W-1:0] sample,
    output logic [DAC_W-1:0] dac
);

    logic [ERR_W-1:0] r_err;
    logic [PCM_W:0]   w_sum;

    assign w_sum = {1'b0, sample} + {{(PCM_W + 1 - ERR_W){1'b0}}, r_err};

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            dac   <= '0;
            r_err <= '0;
        end else if (w_sum[PCM_W]) begin
            // Carry out means the code would exceed full scale: pin both at max
            dac   <= '1;
            r_err <= '1;
        end else begin
            dac   <= w_sum[PCM_W-1 -: DAC_W];
            r_err <= w_sum[ERR_W-1:0];
        end
    end

endmodule

// File: rtl/pdm_audio_dac.sv
// 1-bit PDM in, 16-bit PCM out via a 3rd-order CIC decimator (R = 2^DECIM_LOG2),
// plus a 4-bit noise-shaped code for the board's resistor DAC.
module pdm_audio_dac
    import pdm_audio_pkg::*;
#(
    parameter int DECIM_LOG2 = 6
) (
    input  logic             pixclk,
    input  logic             rst,
    input  logic             pdm_in,
    output logic [PCM_W-1:0] sample,
    output logic             sample_valid,
    output logic [DAC_W-1:0] dac
);

    localparam int G = CIC_ORDER * DECIM_LOG2;
    localparam int W = cic_width(DECIM_LOG2);

    localparam logic [W-1:0] SAT_MAX = {1'b0, {G{1'b1}}};

    logic                  r_pdm_q;
    logic [W-1:0]          r_i1, r_i2, r_i3;
    logic [W-1:0]          r_d0, r_d1, r_d2;
    logic [W-1:0]          r_c1, r_c2, r_c3;
    logic [DECIM_LOG2-1:0] r_decim_cnt;
    logic [1:0]            r_warmup;
    logic [CIC_ORDER-1:0]  r_stage;  // which comb stage the current tick occupies
    logic [CIC_ORDER-1:0]  r_keep;   // that tick arrived after warmup

    logic                  w_tick;
    logic                  w_warm_done;
    logic [PCM_W-1:0]      w_sample;

    assign w_tick      = (r_decim_cnt == {DECIM_LOG2{1'b1}});
    assign w_warm_done = (r_warmup == WARMUP_TICKS);
    // The comb result tops out at exactly 2^G, one code above what G bits hold
    assign w_sample    = (r_c3 > SAT_MAX) ? {PCM_W{1'b1}} : r_c3[G-1 -: PCM_W];

    // NOTE: non-blocking assignments make every stage read the pre-edge value of
    // the stage before it, which is exactly the integrator/comb pipeline wanted.
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            r_pdm_q      <= 1'b0;
            r_i1         <= '0;
            r_i2         <= '0;
            r_i3         <= '0;
            r_d0         <= '0;
            r_d1         <= '0;
            r_d2         <= '0;
            r_c1         <= '0;
            r_c2         <= '0;
            r_c3         <= '0;
            r_decim_cnt  <= '0;
            r_warmup     <= '0;
            r_stage      <= '0;
            r_keep       <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            r_pdm_q     <= pdm_in;
            // Integrators wrap freely; the combs cancel the wrap exactly
            r_i1        <= r_i1 + W'(r_pdm_q);
            r_i2        <= r_i2 + r_i1;
            r_i3        <= r_i3 + r_i2;
            r_decim_cnt <= r_decim_cnt + DECIM_LOG2'(1);
            r_stage     <= {r_stage[CIC_ORDER-2:0], w_tick};
            r_keep      <= {r_keep[CIC_ORDER-2:0], w_tick && w_warm_done};

            if (w_tick) begin
                r_c1 <= r_i3 - r_d0;
                r_d0 <= r_i3;
                if (!w_warm_done) begin
                    r_warmup <= r_warmup + 2'd1;
                end
            end
            if (r_stage[0]) begin
                r_c2 <= r_c1 - r_d1;
                r_d1 <= r_c1;
            end
            if (r_stage[1]) begin
                r_c3 <= r_c2 - r_d2;
                r_d2 <= r_c2;
            end

            sample_valid <= r_stage[2] && r_keep[2];
            if (r_stage[2] && r_keep[2]) begin
                sample <= w_sample;
            end
        end
    end

    dac_noise_shaper u_shaper (
        .pixclk (pixclk),
        .rst    (rst),
        .sample (sample),
        .dac    (dac)
    );

endmodule

// File: tb/tb_pdm_audio_dac.sv
// Bench for pdm_audio_dac: the CIC is modelled as a direct convolution of the
// input bit history with the cubed boxcar kernel, sampled at each tick.
module tb_pdm_audio_dac;

    localparam int R6   = 64;
    localparam int G6   = 18;
    localparam int R8   = 256;
    localparam int G8   = 24;
    localparam int HMAX = 3 * R8 - 2;
    localparam int XMAX = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        pdm_in;
    logic [15:0] sample,  sample8;
    logic        sample_valid, sample_valid8;
    logic [3:0]  dac, dac8;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     edge_cnt = 0;
    bit     x_hist [XMAX];
    longint h6 [HMAX];
    longint h8 [HMAX];

    logic [15:0] exp_s6, exp_s8;
    bit          exp_v6, exp_v8;

    always #20 clk = ~clk;

    pdm_audio_dac #(.DECIM_LOG2(6)) dut (
        .pixclk       (clk),
        .rst          (rst),
        .pdm_in       (pdm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .dac          (dac)
    );

    pdm_audio_dac #(.DECIM_LOG2(8)) dut8 (
        .pixclk       (clk),
        .rst          (rst),
        .pdm_in       (pdm_in),
        .sample       (sample8),
        .sample_valid (sample_valid8),
        .dac          (dac8)
    );

    // Edge 1 is the first rising edge after reset release; x_hist[n] is the
    // input bit sampled on edge n.
    always @(posedge clk) begin
        if (rst) begin
            edge_cnt <= 0;
        end else begin
            if (edge_cnt + 1 < XMAX) x_hist[edge_cnt + 1] <= pdm_in;
            edge_cnt <= edge_cnt + 1;
        end
    end

    // Number of ways three values in [0, r-1] sum to k
    function automatic longint h_coef(input int r, input int k);
        longint c = 0;
        for (int a = 0; a < r; a++) begin
            int m = k - a;
            if (m >= 0 && m <= r - 1)          c += m + 1;
            else if (m >= r && m <= 2 * r - 2) c += 2 * r - 1 - m;
        end
        return c;
    endfunction

    // CIC output for the tick on edge t: the newest input bit it sees was sampled
    // on edge t-4 (input register plus three integrators).
    function automatic logic [15:0] model_sample(input int t, input int r, input int g);
        longint y = 0;
        longint top = (longint'(1) << g) - 1;
        for (int k = 0; k <= 3 * r - 3; k++) begin
            int idx = t - 4 - k;
            if (idx >= 1 && idx < XMAX && x_hist[idx]) y += (r == R6) ? h6[k] : h8[k];
        end
        if (y > top) y = top;
        return 16'(y >> (g - 16));
    endfunction

    task automatic cycle(input bit b);
        pdm_in = b;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_v6 = 1'b0; exp_s6 = '0;
            exp_v8 = 1'b0; exp_s8 = '0;
        end else begin
            exp_v6 = (edge_cnt >= 4 * R6 + 3) && ((edge_cnt - 3) % R6 == 0);
            exp_v8 = (edge_cnt >= 4 * R8 + 3) && ((edge_cnt - 3) % R8 == 0);
            if (exp_v6) exp_s6 = model_sample(edge_cnt - 3, R6, G6);
            if (exp_v8) exp_s8 = model_sample(edge_cnt - 3, R8, G8);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cycle(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cycle(1'b1);
        n_tests++;
        if (sample !== 16'h0 || sample_valid !== 1'b0 || dac !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_r64: sample=%h valid=%b dac=%h want 0/0/0", sample, sample_valid, dac);
        end
        n_tests++;
        if (sample8 !== 16'h0 || sample_valid8 !== 1'b0 || dac8 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_r256: sample=%h valid=%b dac=%h want 0/0/0", sample8, sample_valid8, dac8);
        end
        rst = 1'b0;
    endtask

    task automatic test_const0();
        int first = -1;
        do_reset();
        for (int i = 0; i < 4 * R6 + 3 + 2 * R6; i++) begin
            cycle(1'b0);
            if (sample_valid === 1'b1 && first < 0) first = edge_cnt;
            n_tests++;
            if (sample_valid !== exp_v6 || sample !== exp_s6 || dac !== 4'h0) begin
                n_fail++;
                $display("FAIL const0 edge %0d: valid=%b sample=%h dac=%h want %b/%h/0",
                         edge_cnt, sample_valid, sample, dac, exp_v6, exp_s6);
            end
        end
        n_tests++;
        if (first != 4 * R6 + 3) begin
            n_fail++;
            $display("FAIL const0_first_strobe: got edge %0d want %0d", first, 4 * R6 + 3);
        end
    endtask

    task automatic test_const1();
        do_reset();
        for (int i = 0; i < 4 * R6 + 3 + 2 * R6 + 2; i++) begin
            cycle(1'b1);
            n_tests++;
            if (sample_valid !== exp_v6 || sample !== exp_s6) begin
                n_fail++;
                $display("FAIL const1 edge %0d: valid=%b sample=%h want %b/%h",
                         edge_cnt, sample_valid, sample, exp_v6, exp_s6);
            end
            if (edge_cnt > 4 * R6 + 3) begin
                n_tests++;
                if (sample !== 16'hFFFF || dac !== 4'hF) begin
                    n_fail++;
                    $display("FAIL const1_full edge %0d: sample=%h dac=%h want ffff/f", edge_cnt, sample, dac);
                end
            end
        end
    endtask

    task automatic test_alternating();
        do_reset();
        for (int i = 0; i < 4 * R6 + 3 + 2 * R6; i++) begin
            cycle(i % 2 == 0);
            n_tests++;
            if (sample_valid !== exp_v6 || sample !== exp_s6) begin
                n_fail++;
                $display("FAIL alt edge %0d: valid=%b sample=%h want %b/%h",
                         edge_cnt, sample_valid, sample, exp_v6, exp_s6);
            end
            if (edge_cnt > 4 * R6 + 3) begin
                n_tests++;
                if (sample !== 16'h8000 || dac !== 4'h8) begin
                    n_fail++;
                    $display("FAIL alt_mid edge %0d: sample=%h dac=%h want 8000/8", edge_cnt, sample, dac);
                end
            end
        end
    endtask

    task automatic test_period32();
        logic [3:0] prev = '0;
        int         win  = 0;
        do_reset();
        for (int i = 0; i < 4 * R6 + 3 + 2 * R6; i++) begin
            cycle((i % 32) < 9);
            n_tests++;
            if (sample_valid !== exp_v6 || sample !== exp_s6) begin
                n_fail++;
                $display("FAIL p32 edge %0d: valid=%b sample=%h want %b/%h",
                         edge_cnt, sample_valid, sample, exp_v6, exp_s6);
            end
            if (edge_cnt > 4 * R6 + 3) begin
                n_tests++;
                if (sample !== 16'h4800 || (dac !== 4'h4 && dac !== 4'h5)) begin
                    n_fail++;
                    $display("FAIL p32_level edge %0d: sample=%h dac=%h want 4800/4or5", edge_cnt, sample, dac);
                end
                if (edge_cnt > 4 * R6 + 4) begin
                    n_tests++;
                    if (dac === prev) begin
                        n_fail++;
                        $display("FAIL p32_alternate edge %0d: dac=%h repeated", edge_cnt, dac);
                    end
                end
                if (edge_cnt > 4 * R6 + 3 + 32 && edge_cnt <= 4 * R6 + 3 + 64) win += int'(dac);
            end
            prev = dac;
        end
        n_tests++;
        if (win != 144) begin
            n_fail++;
            $display("FAIL p32_mean: 32-cycle dac sum=%0d want 144", win);
        end
    endtask

    task automatic test_mid_reset();
        int first  = -1;
        int early  = 0;
        do_reset();
        for (int i = 0; i < 5 * R6 + 1; i++) cycle($urandom_range(0, 3) != 0);
        // Edge 5R+1: one edge after a tick, two before its strobe
        rst = 1'b1;
        #1;
        n_tests++;
        if (sample !== 16'h0 || sample_valid !== 1'b0 || dac !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst_async: sample=%h valid=%b dac=%h want 0/0/0", sample, sample_valid, dac);
        end
        cycle(1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4 * R6 + 3 + R6; i++) begin
            cycle($urandom_range(0, 3) != 0);
            if (sample_valid === 1'b1 && first < 0) first = edge_cnt;
            if (sample_valid === 1'b1 && edge_cnt < 4 * R6 + 3) early++;
            n_tests++;
            if (sample_valid !== exp_v6 || sample !== exp_s6) begin
                n_fail++;
                $display("FAIL midrst edge %0d: valid=%b sample=%h want %b/%h",
                         edge_cnt, sample_valid, sample, exp_v6, exp_s6);
            end
        end
        n_tests++;
        if (first != 4 * R6 + 3 || early != 0) begin
            n_fail++;
            $display("FAIL midrst_first_strobe: got edge %0d (%0d early) want %0d", first, early, 4 * R6 + 3);
        end
    endtask

    task automatic test_random();
        int          p;
        bit          win_on  = 1'b0;
        int          win_n   = 0;
        longint      win_sum = 0;
        logic [15:0] win_s   = '0;
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            p = $urandom_range(0, 100);
            for (int i = 0; i < 4 * R6 + (seg == 0 ? 3 : 0); i++) begin
                cycle($urandom_range(0, 99) < p);
                n_tests++;
                if (sample_valid !== exp_v6 || sample !== exp_s6) begin
                    n_fail++;
                    $display("FAIL rand p=%0d edge %0d: valid=%b sample=%h want %b/%h",
                             p, edge_cnt, sample_valid, sample, exp_v6, exp_s6);
                end
                if (win_on) begin
                    win_sum += longint'(dac);
                    win_n++;
                    if (win_n == R6 && win_s <= 16'hF000) begin
                        longint diff = win_sum * 4096 - longint'(R6) * longint'(win_s);
                        n_tests++;
                        if (diff > 4095 || diff < -4095) begin
                            n_fail++;
                            $display("FAIL rand_dac_mean edge %0d: sum(dac)*4096=%0d want %0d +-4095",
                                     edge_cnt, win_sum * 4096, longint'(R6) * longint'(win_s));
                        end
                    end
                end
                if (exp_v6) begin
                    win_on  = 1'b1;
                    win_n   = 0;
                    win_sum = 0;
                    win_s   = exp_s6;
                end
            end
        end
    endtask

    task automatic test_decim8();
        int first = -1;
        do_reset();
        for (int i = 0; i < 4 * R8 + 3 + 2 * R8 + 2; i++) begin
            cycle(1'b1);
            if (sample_valid8 === 1'b1 && first < 0) first = edge_cnt;
            n_tests++;
            if (sample_valid8 !== exp_v8 || sample8 !== exp_s8) begin
                n_fail++;
                $display("FAIL r256 edge %0d: valid=%b sample=%h want %b/%h",
                         edge_cnt, sample_valid8, sample8, exp_v8, exp_s8);
            end
            if (edge_cnt > 4 * R8 + 3) begin
                n_tests++;
                if (sample8 !== 16'hFFFF || dac8 !== 4'hF) begin
                    n_fail++;
                    $display("FAIL r256_full edge %0d: sample=%h dac=%h want ffff/f", edge_cnt, sample8, dac8);
                end
            end
        end
        n_tests++;
        if (first != 4 * R8 + 3) begin
            n_fail++;
            $display("FAIL r256_first_strobe: got edge %0d want %0d", first, 4 * R8 + 3);
        end
    endtask

    initial begin
        rst    = 1'b1;
        pdm_in = 1'b0;
        exp_v6 = 1'b0; exp_s6 = '0;
        exp_v8 = 1'b0; exp_s8 = '0;
        for (int k = 0; k < HMAX; k++) begin
            h6[k] = (k <= 3 * R6 - 3) ? h_coef(R6, k) : 0;
            h8[k] = h_coef(R8, k);
        end
        test_reset();
        test_const0();
        test_const1();
        test_alternating();
        test_period32();
        test_mid_reset();
        test_random();
        test_decim8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
